// File: rtl/channel_decorrelator.sv
// FLAC stereo channel decorrelator: buffers channel 0, then pairs it with channel 1 into left/right.
// Mid/side (mode 0xA) is built only when DECORR_MIDSIDE_EN is defined.
module channel_decorrelator #(
    parameter int MAX_BLOCK = 4608
) (
    input  logic               iClock,
    input  logic               iReset,
    input  logic               iStart,
    input  logic [15:0]        iBlockSize,
    input  logic [3:0]         iChannelAssign,
    input  logic               iSampleValid,
    input  logic signed [16:0] iSample,
    output logic               oValid,
    output logic signed [15:0] oLeft,
    output logic signed [15:0] oRight,
    output logic               oFrameDone,
    output logic               oBusy,
    output logic               oError
);
    localparam int          IDX_W  = (MAX_BLOCK > 1) ? $clog2(MAX_BLOCK) : 1;
    localparam logic [16:0] MAX_BS = 17'(MAX_BLOCK);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FILL  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]         r_state;
    logic [15:0]        r_blockSize;
    logic [15:0]        r_count;
    logic [3:0]         r_mode;
    logic signed [16:0] r_buf [MAX_BLOCK];

    logic               r_s1Valid;
    logic               r_s1Last;
    logic [3:0]         r_s1Mode;
    logic signed [16:0] r_s1Ch0;
    logic signed [16:0] r_s1Ch1;

    logic [IDX_W-1:0]   w_idx;
    logic               w_modeOk;
    logic               w_startOk;
    logic               w_lastSample;
    logic signed [18:0] w_ch0;
    logic signed [18:0] w_ch1;
    logic signed [18:0] w_left;
    logic signed [18:0] w_right;
    logic               w_unusedBits;

    assign w_idx        = r_count[IDX_W-1:0];
    assign w_lastSample = (r_count == r_blockSize - 16'd1);
    assign w_startOk    = w_modeOk && (iBlockSize != 16'd0) && ({1'b0, iBlockSize} <= MAX_BS);
    assign oBusy        = (r_state != IDLE);

    always_comb begin
        case (iChannelAssign)
            4'h1, 4'h8, 4'h9: w_modeOk = 1'b1;
`ifdef DECORR_MIDSIDE_EN
            4'hA:             w_modeOk = 1'b1;
`endif
            default:          w_modeOk = 1'b0;
        endcase
    end

    // The mode travels with each sample so a block started while the pipe drains cannot corrupt it.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            r_state     <= IDLE;
            r_count     <= 16'd0;
            r_blockSize <= 16'd0;
            r_mode      <= 4'd0;
            oError      <= 1'b0;
            r_s1Valid   <= 1'b0;
            r_s1Last    <= 1'b0;
            r_s1Mode    <= 4'd0;
            r_s1Ch1     <= 17'sd0;
        end else begin
            r_s1Valid <= 1'b0;
            r_s1Last  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (iStart) begin
                        if (w_startOk) begin
                            r_blockSize <= iBlockSize;
                            r_mode      <= iChannelAssign;
                            r_count     <= 16'd0;
                            r_state     <= FILL;
                        end else begin
                            oError <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (iSampleValid) begin
                        if (w_lastSample) begin
                            r_count <= 16'd0;
                            r_state <= DRAIN;
                        end else begin
                            r_count <= r_count + 16'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (iSampleValid) begin
                        r_s1Valid <= 1'b1;
                        r_s1Last  <= w_lastSample;
                        r_s1Mode  <= r_mode;
                        r_s1Ch1   <= iSample;
                        if (w_lastSample) begin
                            r_count <= 16'd0;
                            r_state <= IDLE;
                        end else begin
                            r_count <= r_count + 16'd1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Plain RAM: written during FILL, read every cycle at the drain index.
    always_ff @(posedge iClock) begin
        if (r_state == FILL && iSampleValid) begin
            r_buf[w_idx] <= iSample;
        end
        r_s1Ch0 <= r_buf[w_idx];
    end

    assign w_ch0 = {{2{r_s1Ch0[16]}}, r_s1Ch0};
    assign w_ch1 = {{2{r_s1Ch1[16]}}, r_s1Ch1};

`ifdef DECORR_MIDSIDE_EN
    logic signed [18:0] w_mid;
    logic signed [18:0] w_sum;
    logic signed [18:0] w_diff;

    assign w_mid  = {w_ch0[17:0], w_ch1[0]};
    assign w_sum  = w_mid + w_ch1;
    assign w_diff = w_mid - w_ch1;
`endif

    always_comb begin
        w_left  = w_ch0;
        w_right = w_ch1;
        case (r_s1Mode)
            4'h8: w_right = w_ch0 - w_ch1;
            4'h9: w_left  = w_ch0 + w_ch1;
`ifdef DECORR_MIDSIDE_EN
            4'hA: begin
                w_left  = w_sum >>> 1;
                w_right = w_diff >>> 1;
            end
`endif
            default: ;
        endcase
    end

    // Outputs wrap to 16 bits; the discarded upper bits are intentionally dropped.
    assign w_unusedBits = ^{w_left[18:16], w_right[18:16]};

    always_ff @(posedge iClock) begin
        if (iReset) begin
            oValid     <= 1'b0;
            oFrameDone <= 1'b0;
            oLeft      <= 16'sd0;
            oRight     <= 16'sd0;
        end else begin
            oValid     <= r_s1Valid;
            oFrameDone <= r_s1Valid & r_s1Last;
            if (r_s1Valid) begin
                oLeft  <= w_left[15:0];
                oRight <= w_right[15:0];
            end
        end
    end

endmodule

// File: tb/tb_channel_decorrelator.sv
// Directed testbench for channel_decorrelator: hand-computed vectors checked through
// a two-deep expectation pipe that mirrors the 2-cycle output latency.
`timescale 1ns/1ps
module tb_channel_decorrelator;

    logic               iClock = 1'b0;
    logic               iReset = 1'b1;
    logic               iStart = 1'b0;
    logic [15:0]        iBlockSize = 16'd0;
    logic [3:0]         iChannelAssign = 4'd0;
    logic               iSampleValid = 1'b0;
    logic signed [16:0] iSample = 17'sd0;
    logic               oValid;
    logic signed [15:0] oLeft;
    logic signed [15:0] oRight;
    logic               oFrameDone;
    logic               oBusy;
    logic               oError;

    int testsRun    = 0;
    int testsFailed = 0;

    int pV [2] = '{0, 0};
    int pL [2] = '{0, 0};
    int pR [2] = '{0, 0};
    int pD [2] = '{0, 0};

    always #5 iClock = ~iClock;

    channel_decorrelator dut (
        .iClock        (iClock),
        .iReset        (iReset),
        .iStart        (iStart),
        .iBlockSize    (iBlockSize),
        .iChannelAssign(iChannelAssign),
        .iSampleValid  (iSampleValid),
        .iSample       (iSample),
        .oValid        (oValid),
        .oLeft         (oLeft),
        .oRight        (oRight),
        .oFrameDone    (oFrameDone),
        .oBusy         (oBusy),
        .oError        (oError)
    );

    task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                               input logic signed [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // One cycle: check what the DUT shows now, advance the expectation pipe, then drive new inputs.
    task automatic applyStimulus(input int start, input int bs, input int mode, input int sv,
                                 input int smp, input int rst, input int eV, input int eL,
                                 input int eR, input int eD);
        @(negedge iClock);
        checkOutput("oValid", 32'(oValid), pV[1]);
        checkOutput("oFrameDone", 32'(oFrameDone), pD[1]);
        if (pV[1] != 0) begin
            checkOutput("oLeft", 32'(oLeft), pL[1]);
            checkOutput("oRight", 32'(oRight), pR[1]);
        end
        pV[1] = pV[0]; pL[1] = pL[0]; pR[1] = pR[0]; pD[1] = pD[0];
        pV[0] = eV;    pL[0] = eL;    pR[0] = eR;    pD[0] = eD;
        if (rst != 0) begin
            pV = '{0, 0};
            pD = '{0, 0};
        end
        iReset         = (rst != 0);
        iStart         = (start != 0);
        iBlockSize     = 16'(bs);
        iChannelAssign = 4'(mode);
        iSampleValid   = (sv != 0);
        iSample        = 17'(smp);
    endtask

    task automatic idleCycles(input int n);
        repeat (n) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic sendStart(input int bs, input int mode);
        applyStimulus(1, bs, mode, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic sendCh0(input int s);
        applyStimulus(0, 0, 0, 1, s, 0, 0, 0, 0, 0);
    endtask

    task automatic sendCh1(input int s, input int l, input int r, input int done);
        applyStimulus(0, 0, 0, 1, s, 0, 1, l, r, done);
    endtask

    task automatic checkStatus(input int busy, input int err);
        checkOutput("oBusy", 32'(oBusy), busy);
        checkOutput("oError", 32'(oError), err);
    endtask

    task automatic doReset();
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        idleCycles(1);
        checkStatus(0, 0);
        checkOutput("rstLeft", 32'(oLeft), 0);
        checkOutput("rstRight", 32'(oRight), 0);
    endtask

    int b2bCh0 [8] = '{1, 2, 3, 4, 5, 6, 7, 1};
    int b2bCh1 [8] = '{100, 200, 300, 400, 500, 600, 700, 32767};
    int b2bL   [8] = '{101, 202, 303, 404, 505, 606, 707, -32768};

    initial begin
        doReset();

        // Left/side, with a new block started right after the last channel-1 sample
        sendStart(4, 8);
        sendCh0(10);
        checkStatus(1, 0);
        sendCh0(20); sendCh0(30); sendCh0(40);
        sendCh1(1, 10, 9, 0);
        sendCh1(2, 20, 18, 0);
        sendCh1(3, 30, 27, 0);
        sendCh1(4, 40, 36, 1);

        // Independent, with gaps between strobes and full-range 16-bit values
        sendStart(3, 1);
        sendCh0(100); idleCycles(1); sendCh0(-200); sendCh0(32767);
        sendCh1(-5, 100, -5, 0);
        idleCycles(2);
        sendCh1(7, -200, 7, 0);
        sendCh1(-32768, 32767, -32768, 1);
        idleCycles(3);
        checkStatus(0, 0);

        // Right/side back-to-back; a stray iStart during FILL must not change the block
        sendStart(8, 9);
        for (int i = 0; i < 8; i++) begin
            if (i == 2) applyStimulus(1, 2, 1, 1, b2bCh0[i], 0, 0, 0, 0, 0);
            else        sendCh0(b2bCh0[i]);
        end
        for (int i = 0; i < 8; i++) begin
            sendCh1(b2bCh1[i], b2bL[i], b2bCh1[i], (i == 7) ? 1 : 0);
        end
        idleCycles(3);
        checkStatus(0, 0);

        // Stray sample in IDLE, then a one-sample block with a 17-bit side that wraps
        sendCh0(999);
        sendStart(1, 8);
        sendCh0(-32768);
        sendCh1(65535, -32768, -32767, 1);
        idleCycles(3);
        checkStatus(0, 0);

        // Rejected starts
        sendStart(0, 1);
        idleCycles(2);
        checkStatus(0, 1);
        sendCh0(5); sendCh0(6);
        idleCycles(3);
        doReset();

        sendStart(4609, 1);
        idleCycles(2);
        checkStatus(0, 1);
        doReset();

        sendStart(4608, 1);
        idleCycles(1);
        checkStatus(1, 0);
        doReset();

        sendStart(4, 3);
        idleCycles(2);
        checkStatus(0, 1);
        doReset();

`ifdef DECORR_MIDSIDE_EN
        // m = (ch0<<1)|(ch1&1); L = (m+ch1)>>>1, R = (m-ch1)>>>1
        sendStart(2, 10);
        sendCh0(5); sendCh0(-3);
        sendCh1(3, 7, 4, 0);
        sendCh1(-1, -3, -2, 1);
        idleCycles(3);
        checkStatus(0, 0);
`else
        sendStart(2, 10);
        idleCycles(2);
        checkStatus(0, 1);
        sendCh0(5); sendCh0(-3);
        idleCycles(3);
        checkStatus(0, 1);
`endif
        doReset();

        // Reset lands on the third channel-1 sample of a six-sample block
        sendStart(6, 1);
        for (int i = 1; i <= 6; i++) sendCh0(i);
        sendCh1(11, 1, 11, 0);
        sendCh1(12, 2, 12, 0);
        applyStimulus(0, 0, 0, 1, 13, 1, 0, 0, 0, 0);
        idleCycles(1);
        checkOutput("midRstLeft", 32'(oLeft), 0);
        checkOutput("midRstRight", 32'(oRight), 0);
        checkStatus(0, 0);
        idleCycles(1);

        sendStart(2, 8);
        sendCh0(7); sendCh0(-7);
        sendCh1(3, 7, 4, 0);
        sendCh1(-3, -7, -4, 1);
        idleCycles(3);
        checkStatus(0, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
